// File: rtl/accum_sched_if.sv
// Config, request and grant signals of the shared modulo accumulator.
// master drives config/requests; slave is the accumulator side.
interface accum_sched_if #(
  parameter int N = 4,
  parameter int W = 7
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_step;
  logic          cfg_en;
  logic          cfg_clr;
  logic [N-1:0]  req;

  logic          grant_vld;
  logic [N-1:0]  grant;
  logic [W-1:0]  phase_out;
  logic          wrap;
  logic [N-1:0]  ovf;
  logic          cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_step, cfg_en, cfg_clr, req,
    input  grant_vld, grant, phase_out, wrap, ovf, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_step, cfg_en, cfg_clr, req,
    output grant_vld, grant, phase_out, wrap, ovf, cfg_err
  );
endinterface

// File: rtl/accum_sched.sv
// N phase accumulators (modulo M) sharing one adder, served round-robin
// from per-channel request pulses; one registered update per cycle.
module accum_sched #(
  parameter int N = 4,
  parameter int M = 100,
  parameter int W = $clog2(M)
) (
  input  logic        clk,
  input  logic        rst_n,
  accum_sched_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  phase [N];
  logic [W-1:0]  step  [N];
  logic [N-1:0]  en;
  logic [N-1:0]  pending;
  logic [N-1:0]  ovf_q;
  logic [CW-1:0] ptr;

  logic [N-1:0]  elig;
  logic          gnt_found;
  logic [CW-1:0] gnt_idx;
  logic [N-1:0]  gnt_vec;
  logic [W:0]    sum;
  logic          sum_wrap;
  logic [W-1:0]  sum_mod;
  logic          cfg_ok;
  logic          clr_hit;

  logic          grant_vld_q;
  logic [N-1:0]  grant_q;
  logic [W-1:0]  phase_out_q;
  logic          wrap_q;
  logic          cfg_err_q;

  assign elig = pending & en;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!gnt_found && elig[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(c);
      end
    end
  end

  assign gnt_vec  = gnt_found ? (N'(1) << gnt_idx) : '0;
  assign sum      = {1'b0, phase[gnt_idx]} + {1'b0, step[gnt_idx]};
  assign sum_wrap = (sum >= (W+1)'(M));
  assign sum_mod  = sum_wrap ? W'(sum - (W+1)'(M)) : sum[W-1:0];

  // Steps >= M are rejected in W+1 bits so a power-of-two M still compares correctly.
  assign cfg_ok   = bus.cfg_we && ({1'b0, bus.cfg_step} < (W+1)'(M));
  assign clr_hit  = gnt_found && cfg_ok && bus.cfg_clr && (bus.cfg_ch == gnt_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        phase[i] <= '0;
        step[i]  <= '0;
      end
      en      <= '0;
      pending <= '0;
      ovf_q   <= '0;
      ptr     <= CW'(N-1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_ok && (bus.cfg_ch == CW'(i))) begin
          step[i] <= bus.cfg_step;
          en[i]   <= bus.cfg_en;
        end
        if (cfg_ok && bus.cfg_clr && (bus.cfg_ch == CW'(i)))
          phase[i] <= '0;
        else if (gnt_vec[i])
          phase[i] <= sum_mod;
        pending[i] <= bus.req[i] | (pending[i] & ~gnt_vec[i]);
        if (bus.req[i] && pending[i] && !gnt_vec[i])
          ovf_q[i] <= 1'b1;
      end
      if (gnt_found)
        ptr <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld_q <= 1'b0;
      grant_q     <= '0;
      phase_out_q <= '0;
      wrap_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      grant_vld_q <= gnt_found;
      grant_q     <= gnt_vec;
      phase_out_q <= (gnt_found && !clr_hit) ? sum_mod : '0;
      wrap_q      <= gnt_found && !clr_hit && sum_wrap;
      cfg_err_q   <= bus.cfg_we && !cfg_ok;
    end
  end

  assign bus.grant_vld = grant_vld_q;
  assign bus.grant     = grant_q;
  assign bus.phase_out = phase_out_q;
  assign bus.wrap      = wrap_q;
  assign bus.ovf       = ovf_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule
